// File: rtl/rijndael_pkg.sv
// rijndael_pkg: shared Rijndael arithmetic helpers and the key cache state type.
package rijndael_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY,
    STREAM
  } keycache_state_e;

  // Number of cipher rounds for a given block and key size (in 32-bit words).
  function automatic int nr(input int nb, input int nk);
    return ((nb > nk) ? nb : nk) + 6;
  endfunction

  // Multiply by x in GF(2^8) modulo the Rijndael polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) product by shift-and-add.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // S-box computed as the multiplicative inverse (a^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = b;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Apply the S-box to each byte of a word.
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/rijndael_keyschedulestep.sv
// rijndael_keyschedulestep: produces the next NK schedule words from the
// previous NK words and the current round constant (purely combinational).
module rijndael_keyschedulestep
  import rijndael_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic [32*NK-1:0] prev_words,
  input  logic [7:0]       rcon,
  output logic [32*NK-1:0] next_words
);

  logic [31:0] prev_w [NK];
  logic [31:0] next_w [NK];

  // Split the packed key state into words, word 0 in the MSBs.
  always_comb begin
    for (int j = 0; j < NK; j++) prev_w[j] = prev_words[32*(NK-1-j) +: 32];
  end

  // Word recurrence: the first word mixes in RotWord/SubWord/Rcon, the rest chain,
  // and 256-bit keys get an extra SubWord in the middle of the group.
  always_comb begin
    for (int j = 0; j < NK; j++) next_w[j] = '0;
    next_w[0] = prev_w[0] ^ sub_word({prev_w[NK-1][23:0], prev_w[NK-1][31:24]})
                ^ {rcon, 24'h000000};
    for (int j = 1; j < NK; j++) begin
      if (NK > 6 && j == 4) next_w[j] = prev_w[j] ^ sub_word(next_w[j-1]);
      else                  next_w[j] = prev_w[j] ^ next_w[j-1];
    end
  end

  // Repack the new words, word 0 in the MSBs.
  always_comb begin
    next_words = '0;
    for (int j = 0; j < NK; j++) next_words[32*(NK-1-j) +: 32] = next_w[j];
  end

endmodule

// File: rtl/rijndael_keycache.sv
// rijndael_keycache: expands a cipher key once into a local word store, then
// streams the round keys in forward or reverse order over valid/ready.
module rijndael_keycache
  import rijndael_pkg::*;
#(
  parameter int NB = 4,
  parameter int NK = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              key_valid_i,
  output logic                              key_ready_o,
  input  logic [32*NK-1:0]                  key_i,
  input  logic                              start_i,
  input  logic                              decrypt_i,
  output logic                              rk_valid_o,
  input  logic                              rk_ready_i,
  output logic [32*NB-1:0]                  roundkey_o,
  output logic [$clog2(nr(NB, NK)+1)-1:0]   rk_index_o,
  output logic                              rk_last_o
);

  localparam int NR    = nr(NB, NK);
  localparam int NRK   = NR + 1;
  localparam int NW    = NB * NRK;
  localparam int NBLK  = (NW + NK - 1) / NK;
  localparam int STEPS = NBLK - 1;
  localparam int BUFW  = NBLK * NK;
  localparam int IDXW  = $clog2(NRK);
  localparam int SCW   = $clog2(STEPS + 1);

  keycache_state_e  state_q;
  keycache_state_e  state_d;
  logic [31:0]      kbuf [BUFW];
  logic [32*NK-1:0] keystate;
  logic [32*NK-1:0] step_next;
  logic [7:0]       rc;
  logic [SCW-1:0]   step_cnt;
  logic             dir_q;
  logic             load_key;
  logic             start_stream;
  logic             advance;
  logic             finish;
  logic [IDXW-1:0]  rd_idx;
  logic [32*NB-1:0] rd_key;

  rijndael_keyschedulestep #(
    .NK(NK)
  ) u_step (
    .prev_words(keystate),
    .rcon      (rc),
    .next_words(step_next)
  );

  assign key_ready_o = (state_q == IDLE) || (state_q == READY);
  assign rk_last_o   = rk_valid_o && (rk_index_o == (dir_q ? '0 : IDXW'(NR)));

  // State register; reset always returns to IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode; a new key always takes priority over a stream request.
  always_comb begin
    state_d      = state_q;
    load_key     = 1'b0;
    start_stream = 1'b0;
    advance      = 1'b0;
    finish       = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_valid_i) begin
          load_key = 1'b1;
          state_d  = EXPAND;
        end
      end
      EXPAND: begin
        if (step_cnt == SCW'(STEPS - 1)) state_d = READY;
      end
      READY: begin
        if (key_valid_i) begin
          load_key = 1'b1;
          state_d  = EXPAND;
        end else if (start_i) begin
          start_stream = 1'b1;
          state_d      = STREAM;
        end
      end
      STREAM: begin
        if (rk_valid_o && rk_ready_i) begin
          if (rk_last_o) begin
            finish  = 1'b1;
            state_d = READY;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Expansion bookkeeping: running key state, round constant and step count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rc       <= 8'h01;
      step_cnt <= '0;
    end else if (load_key) begin
      keystate <= key_i;
      rc       <= 8'h01;
      step_cnt <= '0;
    end else if (state_q == EXPAND) begin
      keystate <= step_next;
      rc       <= xtime(rc);
      step_cnt <= step_cnt + 1'b1;
    end
  end

  // Word store: the cipher key first, then NK words per step; the tail of the
  // final step past the last round key is discarded.
  always_ff @(posedge clk_i) begin
    if (load_key) begin
      for (int j = 0; j < NK; j++) kbuf[j] <= key_i[32*(NK-1-j) +: 32];
    end else if (state_q == EXPAND) begin
      for (int j = 0; j < NK; j++) begin
        if ((int'(step_cnt) + 1) * NK + j < NW)
          kbuf[(int'(step_cnt) + 1) * NK + j] <= step_next[32*(NK-1-j) +: 32];
      end
    end
  end

  // Index of the round key to load next: the first key of a new stream, or one step on.
  always_comb begin
    rd_idx = rk_index_o;
    if (start_stream)  rd_idx = decrypt_i ? IDXW'(NR) : '0;
    else if (dir_q)    rd_idx = rk_index_o - 1'b1;
    else               rd_idx = rk_index_o + 1'b1;
  end

  // Gather NB consecutive words of the store into one round key, word 0 in the MSBs.
  always_comb begin
    rd_key = '0;
    for (int j = 0; j < NB; j++) rd_key[32*(NB-1-j) +: 32] = kbuf[int'(rd_idx) * NB + j];
  end

  // Registered stream outputs; a key is reloaded on the accepting edge so beats are back to back.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rk_valid_o <= 1'b0;
      roundkey_o <= '0;
      rk_index_o <= '0;
      dir_q      <= 1'b0;
    end else if (start_stream) begin
      rk_valid_o <= 1'b1;
      dir_q      <= decrypt_i;
      rk_index_o <= rd_idx;
      roundkey_o <= rd_key;
    end else if (advance) begin
      rk_index_o <= rd_idx;
      roundkey_o <= rd_key;
    end else if (finish) begin
      rk_valid_o <= 1'b0;
    end
  end

endmodule
